// File: rtl/vector_mask_sequencer_if.sv
// vector_mask_sequencer_if: descriptor and per-beat control handshake bundle
interface vector_mask_sequencer_if #(
    parameter int VLEN = 512
);
    localparam int NUM_BEATS = VLEN / 64;
    localparam int VL_WIDTH = $clog2(VLEN / 8) + 1;
    localparam int BEAT_WIDTH = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
    logic req_valid;
    logic req_ready;
    logic [1:0] req_bit_mode;
    logic [VL_WIDTH-1:0] req_vl;
    logic req_vm;
    logic req_vta;
    logic req_vma;
    logic [VLEN-1:0] req_v0;
    logic beat_valid;
    logic beat_ready;
    logic [BEAT_WIDTH-1:0] beat_index;
    logic [7:0] beat_write_new;
    logic [7:0] beat_fill_ones;
    logic beat_last;
    logic busy;
    modport master (
        output req_valid, req_bit_mode, req_vl, req_vm, req_vta, req_vma, req_v0, beat_ready,
        input req_ready, beat_valid, beat_index, beat_write_new, beat_fill_ones, beat_last, busy
    );
    modport slave (
        input req_valid, req_bit_mode, req_vl, req_vm, req_vta, req_vma, req_v0, beat_ready,
        output req_ready, beat_valid, beat_index, beat_write_new, beat_fill_ones, beat_last, busy
    );
endinterface

// File: rtl/vector_mask_sequencer.sv
// vector_mask_sequencer: walks a destination register beat by beat emitting byte write/fill/keep control
module vector_mask_sequencer #(
    parameter int VLEN = 512
) (
    input logic clock,
    input logic reset,
    vector_mask_sequencer_if.slave bus
);
    localparam int NUM_BEATS = VLEN / 64;
    localparam int VL_WIDTH = $clog2(VLEN / 8) + 1;
    localparam int BEAT_WIDTH = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    logic [0:0] state;
    logic [1:0] sew;
    logic [VL_WIDTH-1:0] vl;
    logic vm;
    logic vta;
    logic vma;
    logic [VLEN-1:0] v0;
    logic [BEAT_WIDTH-1:0] idx;
    logic [BEAT_WIDTH-1:0] next_idx;
    logic [7:0] wn;
    logic [7:0] fo;
    logic last;
    logic [15:0] first_ctrl;
    logic [15:0] next_ctrl;
    // Byte controls for beat b: byte k belongs to element g = b*EPB + k/(bytes per element).
    // The compare is one bit wider than vl so vl beyond the element count never wraps.
    function automatic logic [15:0] beat_ctrl(
        input logic [1:0] s,
        input logic [VL_WIDTH-1:0] l,
        input logic m,
        input logic ta,
        input logic ma,
        input logic [VLEN-1:0] mask,
        input logic [BEAT_WIDTH-1:0] b
    );
        logic [VL_WIDTH:0] g;
        logic [VLEN-1:0] sh;
        logic body;
        logic active;
        logic [7:0] w;
        logic [7:0] f;
        w = '0;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            g = ((VL_WIDTH + 1)'(b) << (2'd3 - s)) + ((VL_WIDTH + 1)'(k) >> s);
            sh = mask >> g;
            body = g < {1'b0, l};
            active = body & (~m | sh[0]);
            w[k] = active;
            f[k] = ~active & (body ? ma : ta);
        end
        return {w, f};
    endfunction
    assign next_idx = idx + 1'b1;
    // Controls for the first beat come straight from the request; later beats from the latched copy
    always_comb begin
        first_ctrl = beat_ctrl(bus.req_bit_mode, bus.req_vl, bus.req_vm, bus.req_vta, bus.req_vma, bus.req_v0, '0);
        next_ctrl = beat_ctrl(sew, vl, vm, vta, vma, v0, next_idx);
    end
    // Accept descriptors in IDLE, then step through every beat of the register under handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sew <= '0;
            vl <= '0;
            vm <= 1'b0;
            vta <= 1'b0;
            vma <= 1'b0;
            v0 <= '0;
            idx <= '0;
            wn <= '0;
            fo <= '0;
            last <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.req_valid) begin
                sew <= bus.req_bit_mode;
                vl <= bus.req_vl;
                vm <= bus.req_vm;
                vta <= bus.req_vta;
                vma <= bus.req_vma;
                v0 <= bus.req_v0;
                if (bus.req_vl != '0) begin
                    state <= ISSUE;
                    idx <= '0;
                    {wn, fo} <= first_ctrl;
                    last <= NUM_BEATS == 1;
                end
            end
        end else if (bus.beat_ready) begin
            if (last) begin
                state <= IDLE;
                idx <= '0;
                wn <= '0;
                fo <= '0;
                last <= 1'b0;
            end else begin
                idx <= next_idx;
                {wn, fo} <= next_ctrl;
                last <= next_idx == BEAT_WIDTH'(NUM_BEATS - 1);
            end
        end
    end
    assign bus.req_ready = state == IDLE;
    assign bus.busy = state == ISSUE;
    assign bus.beat_valid = state == ISSUE;
    assign bus.beat_index = idx;
    assign bus.beat_write_new = wn;
    assign bus.beat_fill_ones = fo;
    assign bus.beat_last = last;
endmodule

// File: tb/tb_vector_mask_sequencer.sv
// tb_vector_mask_sequencer: table vectors, corner sequences and random ops against a byte-level model
module tb_vector_mask_sequencer;
    localparam int VLEN = 512;
    localparam int NB = VLEN / 64;
    localparam int VW = $clog2(VLEN / 8) + 1;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [1:0] m_sew;
    logic [VW-1:0] m_vl;
    logic m_vm, m_vta, m_vma;
    logic [VLEN-1:0] m_v0;
    logic [7:0] got_wn [NB];
    logic [7:0] got_fo [NB];
    typedef struct {
        logic [1:0] sew;
        logic [VW-1:0] vl;
        logic vm;
        logic vta;
        logic vma;
        logic [63:0] v0;
        logic [7:0] wn0;
        logic [7:0] fo0;
        logic [7:0] wn1;
        logic [7:0] fo1;
    } vec_t;
    vec_t tbl [6];
    always #5 clock = ~clock;
    vector_mask_sequencer_if #(.VLEN(VLEN)) bus ();
    vector_mask_sequencer #(.VLEN(VLEN)) dut (.clock(clock), .reset(reset), .bus(bus));
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Byte-address view: byte (b*8+k) of the register belongs to element (b*8+k)/SEW_bytes
    function automatic logic [15:0] model(input int b);
        logic [7:0] w;
        logic [7:0] f;
        int g;
        logic body, act;
        for (int k = 0; k < 8; k++) begin
            g = (b * 8 + k) / (1 << m_sew);
            body = g < int'(m_vl);
            act = body && (!m_vm || m_v0[g]);
            w[k] = act;
            f[k] = !act && (body ? m_vma : m_vta);
        end
        return {w, f};
    endfunction
    task automatic send(input logic [1:0] sew, input logic [VW-1:0] vl, input logic vm, input logic vta,
                        input logic vma, input logic [VLEN-1:0] v0);
        int n;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) check("req_ready_wait", 64'(bus.req_ready), 1);
        m_sew = sew; m_vl = vl; m_vm = vm; m_vta = vta; m_vma = vma; m_v0 = v0;
        bus.req_bit_mode = sew; bus.req_vl = vl; bus.req_vm = vm;
        bus.req_vta = vta; bus.req_vma = vma; bus.req_v0 = v0;
        bus.req_valid = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_vl = VW'($urandom);
        bus.req_bit_mode = 2'($urandom);
        bus.req_v0 = {16{$urandom}};
    endtask
    task automatic collect(input int mode);
        logic [19:0] prev;
        logic held;
        logic [15:0] e;
        int n, cyc, stall;
        held = 1'b0; n = 0; cyc = 0; stall = 0; prev = '0;
        while (n < NB && cyc < 200) begin
            check("no_bubble", 64'(bus.beat_valid), 1);
            if (held) check("hold_stable", 64'({bus.beat_index, bus.beat_write_new, bus.beat_fill_ones, bus.beat_last}), 64'(prev));
            if (mode == 2 && bus.beat_index == 3'd2 && stall < 3) begin
                bus.beat_ready = 1'b0;
                stall++;
            end else begin
                bus.beat_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bus.beat_valid && bus.beat_ready) begin
                e = model(n);
                check("beat_index", 64'(bus.beat_index), 64'(n));
                check("write_new", 64'(bus.beat_write_new), 64'(e[15:8]));
                check("fill_ones", 64'(bus.beat_fill_ones), 64'(e[7:0]));
                check("beat_last", 64'(bus.beat_last), 64'(n == NB - 1));
                got_wn[n] = bus.beat_write_new;
                got_fo[n] = bus.beat_fill_ones;
                n++;
            end
            held = bus.beat_valid && !bus.beat_ready;
            prev = {bus.beat_index, bus.beat_write_new, bus.beat_fill_ones, bus.beat_last};
            @(negedge clock);
            cyc++;
        end
        if (n < NB) check("beat_timeout", 64'(n), 64'(NB));
        if (mode == 2) check("stall_cycles", 64'(stall), 3);
        bus.beat_ready = 1'b0;
        check("ready_after_last", 64'(bus.req_ready), 1);
        check("busy_after_last", 64'(bus.busy), 0);
        check("valid_after_last", 64'(bus.beat_valid), 0);
    endtask
    task automatic run_op(input logic [1:0] sew, input logic [VW-1:0] vl, input logic vm, input logic vta,
                          input logic vma, input logic [VLEN-1:0] v0, input int mode);
        send(sew, vl, vm, vta, vma, v0);
        if (vl == '0) begin
            for (int i = 0; i < 3; i++) begin
                check("vl0_no_valid", 64'(bus.beat_valid), 0);
                check("vl0_ready", 64'(bus.req_ready), 1);
                @(negedge clock);
            end
        end else begin
            collect(mode);
        end
    endtask
    initial begin
        int n;
        bus.req_valid = 1'b0; bus.req_bit_mode = '0; bus.req_vl = '0; bus.req_vm = 1'b0;
        bus.req_vta = 1'b0; bus.req_vma = 1'b0; bus.req_v0 = '0; bus.beat_ready = 1'b0;
        tbl[0] = '{2'd0, 7'd5, 1'b0, 1'b1, 1'b0, 64'h0, 8'h1F, 8'hE0, 8'h00, 8'hFF};
        tbl[1] = '{2'd1, 7'd6, 1'b1, 1'b0, 1'b1, 64'h2D, 8'hF3, 8'h0C, 8'h0C, 8'h03};
        tbl[2] = '{2'd3, 7'd8, 1'b0, 1'b0, 1'b0, 64'h0, 8'hFF, 8'h00, 8'hFF, 8'h00};
        tbl[3] = '{2'd2, 7'd3, 1'b1, 1'b1, 1'b0, 64'h5, 8'h0F, 8'h00, 8'h0F, 8'hF0};
        tbl[4] = '{2'd0, 7'd64, 1'b1, 1'b0, 1'b0, 64'hC3A5, 8'hA5, 8'h00, 8'hC3, 8'h00};
        tbl[5] = '{2'd3, 7'd20, 1'b0, 1'b0, 1'b0, 64'h0, 8'hFF, 8'h00, 8'hFF, 8'h00};
        #1 reset = 1'b1;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 1);
        check("rst_beat_valid", 64'(bus.beat_valid), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_outputs", 64'({bus.beat_index, bus.beat_write_new, bus.beat_fill_ones, bus.beat_last}), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].sew, tbl[i].vl, tbl[i].vm, tbl[i].vta, tbl[i].vma, VLEN'(tbl[i].v0), 0);
            check("tbl_wn0", 64'(got_wn[0]), 64'(tbl[i].wn0));
            check("tbl_fo0", 64'(got_fo[0]), 64'(tbl[i].fo0));
            check("tbl_wn1", 64'(got_wn[1]), 64'(tbl[i].wn1));
            check("tbl_fo1", 64'(got_fo[1]), 64'(tbl[i].fo1));
        end
        run_op(2'd0, 7'd5, 1'b0, 1'b1, 1'b0, '0, 2);
        m_sew = 2'd0; m_vl = 7'd1; m_vm = 1'b0; m_vta = 1'b1; m_vma = 1'b0; m_v0 = '0;
        bus.req_vl = '0; bus.req_bit_mode = 2'd0; bus.req_vm = 1'b0; bus.req_vta = 1'b1;
        bus.req_vma = 1'b0; bus.req_v0 = '0; bus.req_valid = 1'b1;
        @(negedge clock);
        check("vl0_ready_held", 64'(bus.req_ready), 1);
        check("vl0_busy", 64'(bus.busy), 0);
        check("vl0_valid", 64'(bus.beat_valid), 0);
        bus.req_vl = 7'd1;
        @(negedge clock);
        bus.req_valid = 1'b0;
        collect(0);
        check("vl1_beat0_wn", 64'(got_wn[0]), 64'h01);
        check("vl1_beat0_fo", 64'(got_fo[0]), 64'hFE);
        send(2'd0, 7'd64, 1'b0, 1'b0, 1'b0, '0);
        bus.beat_ready = 1'b1;
        n = 0;
        while (bus.beat_index != 3'd4 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("reach_beat4", 64'(bus.beat_index), 4);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(bus.beat_valid), 0);
        check("arst_busy", 64'(bus.busy), 0);
        check("arst_outputs", 64'({bus.beat_index, bus.beat_write_new, bus.beat_fill_ones, bus.beat_last}), 0);
        bus.beat_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("arst_req_ready", 64'(bus.req_ready), 1);
        @(negedge clock);
        run_op(2'd1, 7'd10, 1'b1, 1'b1, 1'b1, VLEN'(64'h3F5), 0);
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0) ? VW'(0) : VW'($urandom_range(1, 64)),
                   1'($urandom), 1'($urandom), 1'($urandom), {16{$urandom}}, 1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
